// File: rtl/spi_master.sv
// SPI master, single-byte full-duplex transfer with runtime-selectable mode 0..3.
// Latency: done pulses 18*CLK_DIV+1 clk cycles after start is presented in IDLE.
// Backpressure: start is level-sampled only in IDLE; requests while busy are ignored.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a loopback input (sample SDO instead of SDI).
module spi_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       SDI,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic       loopback,
`endif
  output logic       sclk,
  output logic       SC,
  output logic       SDO,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] edge_q, edge_d;
  logic       sclk_q, sclk_d;
  logic       sdo_q, sdo_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rxs_q, rxs_d;
  logic [7:0] rx_q, rx_d;
  logic       cpha_q, cpha_d;
  logic       cpol_q, cpol_d;
  logic       done_q, done_d;

  logic       tick;
  logic       leading;
  logic       sample_bit;

  assign tick    = (cnt_q == DIV_LAST);
  assign leading = ~edge_q[0];

`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample_bit = loopback ? sdo_q : SDI;
`else
  assign sample_bit = SDI;
`endif

  // Next-state and datapath: sequencing of setup, 16 sclk edges, hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    sh_d    = sh_q;
    rxs_d   = rxs_q;
    rx_d    = rx_q;
    cpha_d  = cpha_q;
    cpol_d  = cpol_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Idle clock level tracks the live mode input until a transfer is accepted.
        sclk_d = mode[1];
        cnt_d  = 8'd0;
        edge_d = 4'd0;
        if (start) begin
          state_d = SETUP;
          cpha_d  = ^mode;
          cpol_d  = mode[1];
          rxs_d   = 8'h00;
          if (^mode) begin
            // cpha=1: MSB goes out on the first leading edge.
            sh_d = tx_data;
          end else begin
            // cpha=0: MSB must be on the line before the first leading edge.
            sdo_d = tx_data[7];
            sh_d  = {tx_data[6:0], 1'b0};
          end
        end
      end
      SETUP: begin
        cnt_d = cnt_q + 8'd1;
        if (tick) begin
          cnt_d   = 8'd0;
          state_d = TRANSFER;
        end
      end
      TRANSFER: begin
        cnt_d = cnt_q + 8'd1;
        if (tick) begin
          cnt_d  = 8'd0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 4'd1;
          if (leading == cpha_q) begin
            // Launch edge; for cpha=0 the last trailing edge launches nothing.
            if (cpha_q || (edge_q != 4'd15)) begin
              sdo_d = sh_q[7];
              sh_d  = {sh_q[6:0], 1'b0};
            end
          end else begin
            rxs_d = {rxs_q[6:0], sample_bit};
          end
          if (edge_q == 4'd15) begin
            edge_d  = 4'd0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 8'd1;
        if (tick) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
          done_d  = 1'b1;
          rx_d    = rxs_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      edge_q  <= 4'd0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      sh_q    <= 8'h00;
      rxs_q   <= 8'h00;
      rx_q    <= 8'h00;
      cpha_q  <= 1'b0;
      cpol_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      sh_q    <= sh_d;
      rxs_q   <= rxs_d;
      rx_q    <= rx_d;
      cpha_q  <= cpha_d;
      cpol_q  <= cpol_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign SC      = ~busy;
  assign sclk    = sclk_q;
  assign SDO     = sdo_q;
  assign rx_data = rx_q;
  assign done    = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave.
// Expected values are hand-computed constants per vector.
// All outputs sampled on the falling clk edge.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       SDI = 1'b0;
  logic       sclk, SC, SDO, busy, done;
  logic [7:0] rx_data;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // slave model state
  logic [1:0] s_mode = 2'd0;
  logic [7:0] s_byte = 8'h00;
  logic [7:0] mosi   = 8'h00;
  int         sedges = 0;
  int         bitcnt = 0;
  logic       prev_sc = 1'b1;
  logic       prev_sclk = 1'b0;

  spi_master #(.CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .tx_data(tx_data), .SDI(SDI),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .sclk(sclk), .SC(SC), .SDO(SDO), .rx_data(rx_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural slave: launches s_byte MSB first, captures SDO into mosi.
  always @(negedge clk) begin
    logic s_cpha, s_cpol, lead;
    s_cpha = s_mode[0] ^ s_mode[1];
    s_cpol = s_mode[1];
    if (prev_sc && !SC) begin
      bitcnt = 0;
      sedges = 0;
      mosi   = 8'h00;
      if (!s_cpha) SDI = s_byte[7];
    end else if (!SC && (sclk != prev_sclk)) begin
      sedges++;
      lead = (sclk != s_cpol);
      if (lead) begin
        if (s_cpha) begin
          if (bitcnt < 8) SDI = s_byte[3'(7 - bitcnt)];
          bitcnt++;
        end else begin
          mosi = {mosi[6:0], SDO};
        end
      end else begin
        if (s_cpha) begin
          mosi = {mosi[6:0], SDO};
        end else begin
          bitcnt++;
          if (bitcnt < 8) SDI = s_byte[3'(7 - bitcnt)];
        end
      end
    end
    prev_sc   = SC;
    prev_sclk = sclk;
  end

  // Runs one transfer starting at a falling edge; returns at the falling edge where done is seen.
  task automatic run_xfer(input string tag, input logic [1:0] m, input logic [7:0] tx,
                          input logic [7:0] sb, input logic [7:0] exp_rx,
                          input bit disturb, input bit keep_start);
    int cyc;
    s_mode  = m;
    s_byte  = sb;
    mode    = m;
    tx_data = tx;
    start   = 1'b1;
    cyc     = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        check({tag, " busy_after_accept"}, {31'd0, busy}, 32'd1);
        check({tag, " sc_low"}, {31'd0, SC}, 32'd0);
        if (!keep_start) start = 1'b0;
      end
      if (disturb && cyc == 10) begin
        start   = 1'b1;
        tx_data = ~tx;
        mode    = ~m;
      end
      if (disturb && cyc == 12) start = 1'b0;
    end while (!done && cyc < 500);
    if (!keep_start) start = 1'b0;
    check({tag, " latency"}, cyc, 32'd37);
    check({tag, " rx_data"}, {24'd0, rx_data}, {24'd0, exp_rx});
    check({tag, " sdo_bits"}, {24'd0, mosi}, {24'd0, tx});
    check({tag, " sclk_edges"}, sedges, 32'd16);
    check({tag, " sc_high_at_done"}, {31'd0, SC}, 32'd1);
    check({tag, " busy_low_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic idle_lvl(input string tag, input logic [1:0] m);
    mode = m;
    @(negedge clk);
    check({tag, " idle_sclk"}, {31'd0, sclk}, {31'd0, m[1]});
  endtask

  initial begin
    logic [7:0] vec [3];
    int k;
    vec[0] = 8'h01; vec[1] = 8'h80; vec[2] = 8'hFF;

    // reset values
    #12;
    check("rst sclk", {31'd0, sclk}, 32'd0);
    check("rst SC", {31'd0, SC}, 32'd1);
    check("rst SDO", {31'd0, SDO}, 32'd0);
    check("rst rx_data", {24'd0, rx_data}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // mode 0 A5 / 3C
    idle_lvl("m0", 2'd0);
    run_xfer("m0", 2'd0, 8'hA5, 8'h3C, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    check("m0 done_one_cycle", {31'd0, done}, 32'd0);
    check("m0 sdo_hold", {31'd0, SDO}, 32'd1);

    // modes 1..3 96 / 69
    idle_lvl("m1", 2'd1);
    run_xfer("m1", 2'd1, 8'h96, 8'h69, 8'h69, 1'b0, 1'b0);
    @(negedge clk);
    idle_lvl("m2", 2'd2);
    run_xfer("m2", 2'd2, 8'h96, 8'h69, 8'h69, 1'b0, 1'b0);
    @(negedge clk);
    idle_lvl("m3", 2'd3);
    run_xfer("m3", 2'd3, 8'h96, 8'h69, 8'h69, 1'b0, 1'b0);
    @(negedge clk);

    // start held high across three back-to-back transfers
    idle_lvl("held", 2'd0);
    for (k = 0; k < 3; k++) begin
      run_xfer($sformatf("held%0d", k), 2'd0, vec[k], ~vec[k], ~vec[k], 1'b0, 1'b1);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("held no_fourth", {31'd0, busy}, 32'd0);

    // disturbance during a transfer must be ignored
    idle_lvl("dist", 2'd0);
    run_xfer("dist", 2'd0, 8'h5A, 8'hC5, 8'hC5, 1'b1, 1'b0);
    mode = 2'd0;
    repeat (3) @(negedge clk);
    check("dist no_restart", {31'd0, busy}, 32'd0);

`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1'b1;
    idle_lvl("lb", 2'd0);
    run_xfer("lb", 2'd0, 8'hC3, 8'h00, 8'hC3, 1'b0, 1'b0);
    loopback = 1'b0;
    @(negedge clk);
`endif

    // reset after the 4th sclk edge
    begin
      int n;
      logic saw_done;
      saw_done = 1'b0;
      s_mode  = 2'd0;
      s_byte  = 8'h3C;
      mode    = 2'd0;
      tx_data = 8'hA5;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
        if (done) saw_done = 1'b1;
      end while (sedges < 4 && n < 200);
      check("abort edge_count", sedges, 32'd4);
      reset = 1'b0;
      #1;
      check("abort SC", {31'd0, SC}, 32'd1);
      check("abort sclk", {31'd0, sclk}, 32'd0);
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort rx_data", {24'd0, rx_data}, 32'd0);
      mode = 2'd2;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst sclk_cpol", {31'd0, sclk}, 32'd1);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
      end
      check("abort no_done", {31'd0, saw_done}, 32'd0);
      check("abort rx_kept", {24'd0, rx_data}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 2, SHALL set clk cycles per sclk half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 mode  input  2  SPI mode, sampled at start: cpha = (mode==1)|(mode==2), cpol = (mode==2)|(mode==3).
REQ-005 start  input  1  transfer request, level-sampled in IDLE.
REQ-006 tx_data  input  8  byte to send, MSB first, latched at start.
REQ-007 SDI  input  1  serial data from slave (slave SDO).
REQ-008 sclk  output  1  SPI serial clock to slave.
REQ-009 SC  output  1  slave select, active-low.
REQ-010 SDO  output  1  serial data to slave (slave SDI).
REQ-011 rx_data  output  8  last received byte, MSB first.
REQ-012 busy  output  1  high from the cycle after start is accepted until the cycle done asserts.
REQ-013 done  output  1  one-clk pulse marking transfer completion.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, TRANSFER, HOLD; IDLE->SETUP when start=1; SETUP->TRANSFER after CLK_DIV cycles; TRANSFER->HOLD after 16th sclk edge; HOLD->IDLE after CLK_DIV cycles.
REQ-015 On start accept: latch tx_data into shift register, latch mode; SC=0 and busy=1 from the next cycle.
REQ-016 sclk SHALL equal latched cpol in IDLE, SETUP, HOLD; in TRANSFER it SHALL toggle every CLK_DIV cycles, 16 edges (8 leading, 8 trailing).
REQ-017 cpha=0: SDO = bit7 on entering SETUP; sample SDI on each leading edge; shift out next bit on each trailing edge except the 8th.
REQ-018 cpha=1: shift out next bit (bit7 first) on each leading edge; sample SDI on each trailing edge.
REQ-019 Received bits SHALL shift in at LSB; rx_data SHALL update only once, when done asserts, with all 8 bits.
REQ-020 done SHALL pulse for 1 cycle on HOLD->IDLE, same cycle SC returns to 1 and busy to 0; start-to-done latency = 18*CLK_DIV+1 clk cycles.
REQ-021 start while busy SHALL be ignored; start held high SHALL begin a new transfer the cycle after done (SC high for at least 1 cycle).
REQ-022 mode or tx_data changes during a transfer SHALL have no effect on it.
REQ-023 SDO SHALL hold last driven bit after transfer; 0 after reset.

Reset
REQ-024 reset low SHALL immediately force: state IDLE, sclk=0, SC=1, SDO=0, rx_data=8'h00, busy=0, done=0, counters 0.
REQ-025 reset mid-transfer SHALL abort with no done pulse and rx_data unchanged from its reset value 8'h00.
REQ-026 After reset release, sclk SHALL take the cpol of current mode in IDLE from the first clk edge.

Configuration
REQ-027 Macro SPI_MASTER_LOOPBACK_EN defined: input port loopback (1 bit) added; when loopback=1 sampling SHALL use internal SDO instead of SDI, pins still driven normally.
REQ-028 Macro undefined: no loopback port, sampling SHALL always use SDI.

Verification
REQ-029 Mode 0, CLK_DIV=2, tx_data=8'hA5, slave model returns 8'h3C -> SDO bits 1,0,1,0,0,1,0,1 on leading edges; rx_data=8'h3C; done 37 cycles after start.
REQ-030 Modes 1,2,3 each with tx_data=8'h96, slave returns 8'h69 -> correct sclk idle level, correct edges, rx_data=8'h69.
REQ-031 start held high for 3 transfers, tx_data 8'h01/8'h80/8'hFF -> three done pulses, SC high >=1 cycle between, data correct.
REQ-032 reset asserted after 4th sclk edge -> SC=1, sclk=0, busy=0 immediately; no done; rx_data=8'h00.
REQ-033 start pulsed and tx_data/mode changed during transfer -> ignored; original byte sent.
REQ-034 SPI_MASTER_LOOPBACK_EN, loopback=1, SDI tied 0, tx_data=8'hC3 -> rx_data=8'hC3.
